// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sa_state_t;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder made from two half adders and an OR of their carries.
module full_adder_1b (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .x (x),
        .y (y),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .x (s0),
        .y (ci),
        .s (s),
        .c (c1)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; building block of full_adder_1b.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder reused LSB-first across WIDTH bits,
// with a start/busy/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold the last result
//   RUN   | one operand bit per clock through the full adder
//   DONE  | done pulses for one cycle; start here is accepted back-to-back
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_next;

    full_adder_1b u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // The newest bit enters at the MSB; after WIDTH bits this is the full sum.
    assign res_next = {fa_s, res_sr};

    // Sequencer: operand capture, per-bit shift/carry update and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    res_sr <= res_next[WIDTH-1:1];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sum   <= res_next;
                        cout  <= fa_co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a cycle-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted add yields a+b+cin exactly W cycles later.
    int         m_left = 0;
    logic [W:0] m_res = '0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [W:0] m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_res  = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_out  = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_out  = m_res;
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_res  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_left = W;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle {busy,done,cout,sum}", {busy, done, cout, sum}, {m_busy, m_done, m_out[W], m_out[W-1:0]});
    end

    task automatic wait_done(input int budget, output int n, output int bc, output bit seen);
        n = 0;
        bc = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
    endtask

    task automatic run_add(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic c_i,
                           input logic [W-1:0] exp_s, input logic exp_c, input string nm);
        int n;
        int bc;
        bit seen;
        @(posedge clk);
        #2;
        a = a_i; b = b_i; cin = c_i; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0; a = ~a_i; b = ~b_i; cin = ~c_i;
        wait_done(3 * W, n, bc, seen);
        chk({nm, " done seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({nm, " latency"}, 64'(n), 64'(W + 1));
            chk({nm, " busy cycles"}, 64'(bc), 64'(W));
            chk({nm, " sum"}, 64'(sum), 64'(exp_s));
            chk({nm, " cout"}, 64'(cout), 64'(exp_c));
        end
    endtask

    logic [W-1:0] hs_a [4] = '{8'h01, 8'h80, 8'h7F, 8'hF0};
    logic [W-1:0] hs_b [4] = '{8'h02, 8'h80, 8'h01, 8'h0F};
    logic         hs_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] hs_s [4] = '{8'h03, 8'h00, 8'h81, 8'h00};
    logic         hs_o [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int k;
        int cyc;
        int last;
        int ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rt;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {busy, done, cout, sum}, '0);
        #1;
        rst_n = 1'b1;

        run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
        run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5+5a+1");
        run_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "3c+42");

        // Start while busy must be ignored.
        @(posedge clk);
        #2;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        a = 8'h11; b = 8'h11; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("ignore sum", 64'(sum), 64'h46);
                    chk("ignore cout", 64'(cout), 64'd0);
                end
            end
        end
        chk("ignore done count", 64'(ndone), 64'd1);

        // Start held high: back-to-back adds every W+1 cycles.
        @(posedge clk);
        #2;
        a = hs_a[0]; b = hs_b[0]; cin = hs_c[0]; start = 1'b1;
        k = 0;
        cyc = 0;
        last = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk("held sum", 64'(sum), 64'(hs_s[k]));
                chk("held cout", 64'(cout), 64'(hs_o[k]));
                if (k > 0) chk("held interval", 64'(cyc - last), 64'(W + 1));
                last = cyc;
                k++;
                if (k < 4) begin
                    a = hs_a[k]; b = hs_b[k]; cin = hs_c[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("held done count", 64'(k), 64'd4);

        // Reset in the middle of a run.
        @(posedge clk);
        #2;
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {busy, done, cout, sum}, '0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no done after abort", 64'(ndone), 64'd0);
        run_add(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "ff+ff after reset");

        // Random sweep.
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1, 0));
            rt = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_add(ra, rb, rc, rt[W-1:0], rt[W], "rand");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
